// File: rtl/encoder_behavioral.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_behavioral
//  Description : Three-line priority encoder (a > b > c) with registered
//                code, valid flag and a one-cycle "code changed" pulse.
//                Loads are gated by a sample enable.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_behavioral (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       en,
   output logic [1:0] outp,
   output logic       valid,
   output logic       changed
);

   logic [1:0] w_code;
   logic       w_any;
   logic [1:0] r_outp;
   logic       r_valid;
   logic       r_changed;

   // Priority code: a wins over b, b wins over c; all eight cases covered.
   always_comb begin
      w_code = 2'b00;
      if (a)
         w_code = 2'b11;
      else if (b)
         w_code = 2'b10;
      else if (c)
         w_code = 2'b01;
      else
         w_code = 2'b00;
   end

   assign w_any = a | b | c;

   // Output registers: load on enabled edges, pulse changed when the code moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outp    <= 2'b00;
         r_valid   <= 1'b0;
         r_changed <= 1'b0;
      end else if (en) begin
         r_outp    <= w_code;
         r_valid   <= w_any;
         r_changed <= (w_code != r_outp);
      end else begin
         r_changed <= 1'b0;
      end
   end

   assign outp    = r_outp;
   assign valid   = r_valid;
   assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_encoder_behavioral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_behavioral
//  Description : Scoreboard bench for encoder_behavioral. Stimulus pushes the
//                reference response per cycle; a monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_behavioral;

   logic       clk;
   logic       rst_n;
   logic       a, b, c, en;
   logic [1:0] outp;
   logic       valid;
   logic       changed;

   int n_tests;
   int n_fail;
   int n_cycle;

   // expected response packed as {outp[1:0], valid, changed}
   logic [3:0] exp_q[$];

   // reference model state
   logic [1:0] m_outp;
   logic       m_valid;
   logic [1:0] code_tbl [8];

   encoder_behavioral dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .c       (c),
      .en      (en),
      .outp    (outp),
      .valid   (valid),
      .changed (changed)
   );

   // free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%b required=%b", name, act, req);
      end
   endtask

   // drive one cycle of inputs before the next rising edge and push the reference result
   task automatic step(input logic ia, input logic ib, input logic ic, input logic ien);
      logic       exp_chg;
      logic [1:0] nc;
      @(negedge clk);
      a  = ia;
      b  = ib;
      c  = ic;
      en = ien;
      exp_chg = 1'b0;
      if (ien) begin
         nc      = code_tbl[{ia, ib, ic}];
         exp_chg = (nc != m_outp);
         m_outp  = nc;
         m_valid = ia | ib | ic;
      end
      exp_q.push_back({m_outp, m_valid, exp_chg});
   endtask

   // monitor: after every rising edge, compare whatever the stimulus queued
   initial begin
      logic [3:0] e;
      n_cycle = 0;
      forever begin
         @(posedge clk);
         #1;
         n_cycle++;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("scoreboard cycle %0d", n_cycle), {outp, valid, changed}, e);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      code_tbl[0] = 2'b00; code_tbl[1] = 2'b01; code_tbl[2] = 2'b10; code_tbl[3] = 2'b10;
      code_tbl[4] = 2'b11; code_tbl[5] = 2'b11; code_tbl[6] = 2'b11; code_tbl[7] = 2'b11;
      m_outp  = 2'b00;
      m_valid = 1'b0;
      a = 0; b = 0; c = 0; en = 0;

      // power-on reset, held across edges while the inputs try to load
      rst_n = 1'b0;
      a = 1; en = 1;
      repeat (3) @(posedge clk);
      #1;
      check("reset state", {outp, valid, changed}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      a = 0; en = 0;

      // exhaustive sweep of the eight input combinations
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         step(v[2], v[1], v[0], 1'b1);
      end

      // priority conflict: all set, then drop a, then drop b
      step(1, 1, 1, 1);
      step(0, 1, 1, 1);
      step(0, 0, 1, 1);

      // hold: outp=10, then en=0 with a asserted for five cycles, then enable
      step(0, 1, 0, 1);
      repeat (5) step(1, 0, 0, 0);
      step(1, 0, 0, 1);

      // no-change: 011 held four cycles from an idle start
      step(0, 0, 0, 1);
      repeat (4) step(0, 1, 1, 1);

      // async reset between edges with outp=11
      step(1, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async reset outp",    {2'b00, outp},    {2'b00, 2'b00});
      check("async reset valid",   {3'b000, valid},  4'b0000);
      check("async reset changed", {3'b000, changed}, 4'b0000);
      m_outp  = 2'b00;
      m_valid = 1'b0;
      exp_q.delete();
      // release with 001 driven on the same cycle
      step(0, 0, 1, 1);
      rst_n = 1'b1;

      // idle after outp=01
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // randomized traffic with an occasionally low enable
      for (int k = 0; k < 300; k++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end

      // let the monitor drain; bounded wait
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: actual=%0d pending required=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
